// File: rtl/an_rx_bit_dec.sv
`default_nettype none
// ============================================================================
// Module   : an_rx_bit_dec
// Brief    : Tone-keyed byte decoder. Slices each level measurement with
//            hysteresis and frames the sliced stream as async serial
//            (start=tone, 8 data bits LSB first, stop=silence).
// Revision : 1.0 - initial release
// ============================================================================
module an_rx_bit_dec #(
    parameter int unsigned C_LV_W  = 12,
    parameter int unsigned C_TH_HI = 1000,
    parameter int unsigned C_TH_LO = 600,
    parameter int unsigned C_SPB   = 4
) (
    input  logic              CK_i,
    input  logic              XARST_i,
    input  logic [C_LV_W-1:0] LVs_i,
    input  logic              DONE_i,
    output logic              SLC_o,
    output logic [7:0]        DAT_o,
    output logic              DAT_EN_o,
    output logic              FRM_ERR_o,
    output logic              BUSY_o
);

    localparam int unsigned CNT_W = $clog2(C_SPB) + 1;

    localparam logic [C_LV_W-1:0] c_th_hi   = C_LV_W'(C_TH_HI);
    localparam logic [C_LV_W-1:0] c_th_lo   = C_LV_W'(C_TH_LO);
    localparam logic [CNT_W-1:0]  c_spb     = CNT_W'(C_SPB);
    localparam logic [CNT_W-1:0]  c_spb_hlf = CNT_W'(C_SPB / 2);
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
    localparam logic [3:0]        c_bit_lst = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_WAITLO = 3'd4
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [3:0]       r_bit, w_bit_nx;
    logic [7:0]       r_sr, w_sr_nx;
    logic [7:0]       r_dat, w_dat_nx;
    logic             r_dat_en, w_dat_en_nx;
    logic             r_frm_err, w_frm_err_nx;
    logic             r_slc, w_slc_nx;

    // Levels between the two thresholds keep the previous decision.
    always_comb begin
        w_slc_nx = r_slc;
        if (DONE_i) begin
            if (LVs_i >= c_th_hi) begin
                w_slc_nx = 1'b1;
            end else if (LVs_i < c_th_lo) begin
                w_slc_nx = 1'b0;
            end
        end
    end

    assign w_cnt_inc = r_cnt + c_cnt_one;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_bit_nx     = r_bit;
        w_sr_nx      = r_sr;
        w_dat_nx     = r_dat;
        w_dat_en_nx  = 1'b0;
        w_frm_err_nx = 1'b0;
        if (DONE_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_slc_nx) begin
                        w_state_nx = S_START;
                        w_cnt_nx   = '0;
                    end
                end
                S_START: begin
                    w_cnt_nx = w_cnt_inc;
                    // Re-check the tone at the middle of the start bit to reject glitches.
                    if (w_cnt_inc == c_spb_hlf) begin
                        w_cnt_nx = '0;
                        if (w_slc_nx) begin
                            w_state_nx = S_DATA;
                            w_bit_nx   = '0;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == c_spb) begin
                        w_sr_nx  = {w_slc_nx, r_sr[7:1]};
                        w_cnt_nx = '0;
                        w_bit_nx = r_bit + 4'd1;
                        if (r_bit == c_bit_lst) begin
                            w_state_nx = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == c_spb) begin
                        w_cnt_nx = '0;
                        if (!w_slc_nx) begin
                            w_dat_nx    = r_sr;
                            w_dat_en_nx = 1'b1;
                            w_state_nx  = S_IDLE;
                        end else begin
                            w_frm_err_nx = 1'b1;
                            w_state_nx   = S_WAITLO;
                        end
                    end
                end
                S_WAITLO: begin
                    // A stuck tone must drop before a new start bit can be taken.
                    if (!w_slc_nx) begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_sr      <= '0;
            r_dat     <= '0;
            r_dat_en  <= 1'b0;
            r_frm_err <= 1'b0;
            r_slc     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit     <= w_bit_nx;
            r_sr      <= w_sr_nx;
            r_dat     <= w_dat_nx;
            r_dat_en  <= w_dat_en_nx;
            r_frm_err <= w_frm_err_nx;
            r_slc     <= w_slc_nx;
        end
    end

    assign SLC_o     = r_slc;
    assign DAT_o     = r_dat;
    assign DAT_EN_o  = r_dat_en;
    assign FRM_ERR_o = r_frm_err;
    assign BUSY_o    = (r_state != S_IDLE);

endmodule
`default_nettype wire
